// File: rtl/m72_rom_fetch_arbiter.sv
// Round-robin arbiter sharing one graphics-ROM SDRAM fetch channel between
// the tile/sprite fetchers, with per-port request latching and a stall watchdog.
module m72_rom_fetch_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 20,
   parameter int TIMEOUT   = 64
) (
   input  logic                        CLK_32M,
   input  logic                        RESET,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   output logic [NUM_PORTS-1:0]        rdy,
   output logic [31:0]                 rom_data,
   output logic [NUM_PORTS-1:0]        overrun,
   output logic                        timeout_err,
   input  logic                        err_clr,
   output logic [ADDR_W-1:0]           sdr_addr,
   output logic                        sdr_req,
   input  logic [31:0]                 sdr_data,
   input  logic                        sdr_rdy
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                state, state_nxt;
   logic [NUM_PORTS-1:0]  pending;
   logic [ADDR_W-1:0]     addr_q [NUM_PORTS];
   logic [PW-1:0]         last_grant, owner, gnt_idx;
   logic                  gnt_vld;
   logic [PW:0]           cand;
   logic [7:0]            timer;
   logic                  do_grant, done_ok, done_to;

   // First pending port strictly after last_grant, wrapping around.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = {1'b0, last_grant} + (PW+1)'(k);
         if (cand >= (PW+1)'(NUM_PORTS))
            cand = cand - (PW+1)'(NUM_PORTS);
         if (!gnt_vld && pending[cand[PW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge CLK_32M) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      case (state)
         S_IDLE: begin
            if (gnt_vld) begin
               do_grant  = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (sdr_rdy) begin
               done_ok   = 1'b1;
               state_nxt = S_IDLE;
            end else if (timer == TMAX) begin
               done_to   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK_32M) begin
      if (RESET) begin
         pending     <= '0;
         last_grant  <= PW'(NUM_PORTS - 1);
         owner       <= '0;
         timer       <= '0;
         sdr_req     <= 1'b0;
         sdr_addr    <= '0;
         rdy         <= '0;
         rom_data    <= '0;
         overrun     <= '0;
         timeout_err <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) addr_q[i] <= '0;
      end else begin
         sdr_req <= do_grant;
         rdy     <= '0;
         timer   <= timer + 8'd1;

         if (do_grant) begin
            sdr_addr   <= addr_q[gnt_idx];
            owner      <= gnt_idx;
            last_grant <= gnt_idx;
            timer      <= '0;
         end

         if (done_ok) begin
            rom_data   <= sdr_data;
            rdy[owner] <= 1'b1;
         end
         if (done_to) begin
            rom_data   <= '0;
            rdy[owner] <= 1'b1;
         end

         // Clear first so a same-cycle error event keeps its flag set.
         if (err_clr) begin
            overrun     <= '0;
            timeout_err <= 1'b0;
         end
         if (done_to) timeout_err <= 1'b1;

         for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i]) begin
               addr_q[i]  <= req_addr[i*ADDR_W +: ADDR_W];
               pending[i] <= 1'b1;
               // A request being issued this cycle is not overwritten.
               if (pending[i] && !(do_grant && gnt_idx == PW'(i)))
                  overrun[i] <= 1'b1;
            end else if (do_grant && gnt_idx == PW'(i)) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_m72_rom_fetch_arbiter.sv
// Directed bench for m72_rom_fetch_arbiter: per-cycle vector table plus
// hand-written fairness, watchdog and reset-in-flight sequences.
module tb_m72_rom_fetch_arbiter;

   logic        CLK_32M = 1'b0;
   logic        RESET   = 1'b1;
   logic [2:0]  req;
   logic [59:0] req_addr;
   logic [2:0]  rdy;
   logic [31:0] rom_data;
   logic [2:0]  overrun;
   logic        timeout_err;
   logic        err_clr;
   logic [19:0] sdr_addr;
   logic        sdr_req;
   logic [31:0] sdr_data;
   logic        sdr_rdy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   m72_rom_fetch_arbiter #(.NUM_PORTS(3), .ADDR_W(20), .TIMEOUT(8)) dut (
      .CLK_32M(CLK_32M), .RESET(RESET), .req(req), .req_addr(req_addr),
      .rdy(rdy), .rom_data(rom_data), .overrun(overrun),
      .timeout_err(timeout_err), .err_clr(err_clr), .sdr_addr(sdr_addr),
      .sdr_req(sdr_req), .sdr_data(sdr_data), .sdr_rdy(sdr_rdy)
   );

   always #5 CLK_32M = ~CLK_32M;
   always @(posedge CLK_32M) cyc <= cyc + 1;

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [59:0] addr;
      logic        srdy;
      logic [31:0] sdata;
      logic        eclr;
      logic [2:0]  e_rdy;
      logic [31:0] e_rom;
      logic        e_sreq;
      logic [19:0] e_saddr;
      logic [2:0]  e_ovr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit [31:0] rst, bit [31:0] rq, bit [31:0] a0,
                              bit [31:0] a1, bit [31:0] a2, bit [31:0] srdy,
                              bit [31:0] sd, bit [31:0] ec, bit [31:0] erdy,
                              bit [31:0] erom, bit [31:0] esreq,
                              bit [31:0] esaddr, bit [31:0] eovr);
      vec_t r;
      r.rst     = 1'(rst);
      r.req     = 3'(rq);
      r.addr    = {20'(a2), 20'(a1), 20'(a0)};
      r.srdy    = 1'(srdy);
      r.sdata   = sd;
      r.eclr    = 1'(ec);
      r.e_rdy   = 3'(erdy);
      r.e_rom   = erom;
      r.e_sreq  = 1'(esreq);
      r.e_saddr = 20'(esaddr);
      r.e_ovr   = 3'(eovr);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic idle();
      req      = '0;
      req_addr = '0;
      sdr_rdy  = 1'b0;
      sdr_data = '0;
      err_clr  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK_32M);
      idle();
      RESET = 1'b1;
      @(negedge CLK_32M);
      RESET = 1'b0;
   endtask

   // which: 0 = wait for sdr_req, 1 = wait for any rdy. at = -1 on expiry.
   task automatic wait_out(input int which, input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim && at < 0; i++) begin
         @(negedge CLK_32M);
         idle();
         if (which == 0 ? sdr_req : (rdy != 3'b000)) at = cyc;
      end
   endtask

   logic [19:0] gaddr [3];
   int ngr, age, consec, s_at, r_at;
   logic prev;

   initial begin
      idle();

      // Single request on port 1
      tbl.push_back(v(1,'b010,0,'h12345,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,1,'h12345,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,'h12345,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,'h12345,0));
      tbl.push_back(v(0,0,0,0,0, 1,32'hDEADBEEF,0, 0,0,0,'h12345,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 'b010,32'hDEADBEEF,0,'h12345,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'hDEADBEEF,0,'h12345,0));
      // Simultaneous requests, sdr_rdy two cycles after each sdr_req
      tbl.push_back(v(1,'b111,'h100,'h200,'h300, 0,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,1,'h100,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,'h100,0));
      tbl.push_back(v(0,0,0,0,0, 1,32'hA0000001,0, 0,0,0,'h100,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 'b001,32'hA0000001,0,'h100,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'hA0000001,1,'h200,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'hA0000001,0,'h200,0));
      tbl.push_back(v(0,0,0,0,0, 1,32'hA0000002,0, 0,32'hA0000001,0,'h200,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 'b010,32'hA0000002,0,'h200,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'hA0000002,1,'h300,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'hA0000002,0,'h300,0));
      tbl.push_back(v(0,0,0,0,0, 1,32'hA0000003,0, 0,32'hA0000002,0,'h300,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 'b100,32'hA0000003,0,'h300,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'hA0000003,0,'h300,0));
      // Overrun on port 2 while port 0 is in flight, then err_clr
      tbl.push_back(v(1,'b001,'h050,0,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,'b100,0,0,'h010, 0,0,0, 0,0,1,'h050,0));
      tbl.push_back(v(0,'b100,0,0,'h020, 0,0,0, 0,0,0,'h050,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,'h050,'b100));
      tbl.push_back(v(0,0,0,0,0, 1,32'h11111111,0, 0,0,0,'h050,'b100));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 'b001,32'h11111111,0,'h050,'b100));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'h11111111,1,'h020,'b100));
      tbl.push_back(v(0,0,0,0,0, 1,32'h22222222,0, 0,32'h11111111,0,'h020,'b100));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 'b100,32'h22222222,0,'h020,'b100));
      tbl.push_back(v(0,0,0,0,0, 0,0,1, 0,32'h22222222,0,'h020,'b100));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'h22222222,0,'h020,0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,32'h22222222,0,'h020,0));

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         @(negedge CLK_32M);
         chk($sformatf("row%0d rdy", i),      rdy,         tbl[i].e_rdy);
         chk($sformatf("row%0d rom_data", i), rom_data,    tbl[i].e_rom);
         chk($sformatf("row%0d sdr_req", i),  sdr_req,     tbl[i].e_sreq);
         chk($sformatf("row%0d sdr_addr", i), sdr_addr,    tbl[i].e_saddr);
         chk($sformatf("row%0d overrun", i),  overrun,     tbl[i].e_ovr);
         chk($sformatf("row%0d timeout", i),  timeout_err, 1'b0);
         idle();
         req      = tbl[i].req;
         req_addr = tbl[i].addr;
         sdr_rdy  = tbl[i].srdy;
         sdr_data = tbl[i].sdata;
         err_clr  = tbl[i].eclr;
      end

      // Fairness: port 0 re-requests on every rdy while port 2 waits
      do_reset();
      ngr = 0; age = -1; consec = 0; prev = 1'b0;
      for (int c = 0; c < 60 && ngr < 3; c++) begin
         @(negedge CLK_32M);
         idle();
         if (sdr_req) begin
            if (prev) consec++;
            gaddr[ngr] = sdr_addr;
            ngr++;
            age = 0;
         end else if (age >= 0) age++;
         prev = sdr_req;
         if (age == 2) begin sdr_rdy = 1'b1; sdr_data = 32'h0000_00F0; age = -1; end
         if (c == 0) begin req[0] = 1'b1; req_addr[19:0] = 20'h000A0; end
         if (c == 2) begin req[2] = 1'b1; req_addr[59:40] = 20'h000C0; end
         if (rdy[0]) begin req[0] = 1'b1; req_addr[19:0] = 20'h000A1; end
      end
      chk("fair grant count", ngr, 3);
      if (ngr == 3) begin
         chk("fair grant0", gaddr[0], 20'h000A0);
         chk("fair grant1 port2", gaddr[1], 20'h000C0);
         chk("fair grant2 port0", gaddr[2], 20'h000A1);
      end
      chk("fair back-to-back sdr_req", consec, 0);

      // Watchdog and stray ready
      do_reset();
      @(negedge CLK_32M); req = 3'b010; req_addr[39:20] = 20'h00ABC;
      wait_out(0, 10, s_at);
      chk("to first sdr_req seen", s_at >= 0, 1'b1);
      @(negedge CLK_32M); sdr_rdy = 1'b1; sdr_data = 32'h5A5A5A5A;
      wait_out(1, 5, r_at);
      chk("to first rdy seen", r_at >= 0, 1'b1);
      chk("to first rdy", rdy, 3'b010);
      chk("to first rom_data", rom_data, 32'h5A5A5A5A);
      @(negedge CLK_32M); req = 3'b010; req_addr[39:20] = 20'h00ABD;
      wait_out(0, 10, s_at);
      chk("to sdr_addr", sdr_addr, 20'h00ABD);
      wait_out(1, 20, r_at);
      chk("to rdy latency", r_at - s_at, 8);
      chk("to rdy", rdy, 3'b010);
      chk("to rom_data zero", rom_data, 32'h0);
      chk("to timeout_err", timeout_err, 1'b1);
      @(negedge CLK_32M); idle(); sdr_rdy = 1'b1; sdr_data = 32'hFFFFFFFF;
      @(negedge CLK_32M); idle();
      chk("stray rdy", rdy, 3'b000);
      chk("stray rom_data", rom_data, 32'h0);
      chk("stray timeout_err held", timeout_err, 1'b1);
      err_clr = 1'b1;
      @(negedge CLK_32M); idle();
      chk("to err_clr", timeout_err, 1'b0);

      // Reset while port 0 in flight and port 1 pending
      do_reset();
      @(negedge CLK_32M); req = 3'b001; req_addr[19:0] = 20'h00111;
      @(negedge CLK_32M); idle();
      @(negedge CLK_32M); idle();
      chk("rst pre sdr_req", sdr_req, 1'b1);
      chk("rst pre sdr_addr", sdr_addr, 20'h00111);
      @(negedge CLK_32M); req = 3'b010; req_addr[39:20] = 20'h00222;
      @(negedge CLK_32M); idle(); RESET = 1'b1;
      @(negedge CLK_32M); RESET = 1'b0;
      chk("rst outputs", {sdr_req, sdr_addr, rdy, rom_data, overrun, timeout_err}, 60'h0);
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK_32M); idle();
         if (c == 1) begin sdr_rdy = 1'b1; sdr_data = 32'h77777777; end
         chk($sformatf("rst quiet c%0d", c), {sdr_req, rdy, rom_data}, 36'h0);
      end
      @(negedge CLK_32M); req = 3'b100; req_addr[59:40] = 20'h00333;
      @(negedge CLK_32M); idle();
      @(negedge CLK_32M); idle();
      chk("post-rst sdr_req", sdr_req, 1'b1);
      chk("post-rst sdr_addr", sdr_addr, 20'h00333);
      @(negedge CLK_32M); idle(); sdr_rdy = 1'b1; sdr_data = 32'h33333333;
      @(negedge CLK_32M); idle();
      chk("post-rst rdy", rdy, 3'b100);
      chk("post-rst rom_data", rom_data, 32'h33333333);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
